// File: rtl/i_decode.sv
`default_nettype none
// ============================================================================
// i_decode : MIPS ID stage with register file, control decode and ID/EX latch.
//            Optional load-use hazard unit enabled by macro ID_HAZARD_EN.
// Revision  : 1.0
// ============================================================================
module i_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_instr,
  input  logic [31:0] IF_ID_npc,
  input  logic        EX_MEM_PCSrc,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_WriteReg,
  input  logic [31:0] MEM_WB_WriteData,
  output logic [1:0]  ID_EX_wb,
  output logic [2:0]  ID_EX_m,
  output logic [3:0]  ID_EX_ex,
  output logic [31:0] ID_EX_npc,
  output logic [31:0] ID_EX_readdat1,
  output logic [31:0] ID_EX_readdat2,
  output logic [31:0] ID_EX_sign_ext,
  output logic [4:0]  ID_EX_instr_2016,
  output logic [4:0]  ID_EX_instr_1511,
  output logic        IF_ID_stall
);

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_beq   = 6'h04;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [1:0]  wb_dec, wb_d, wb_q;
  logic [2:0]  m_dec, m_d, m_q;
  logic [3:0]  ex_dec, ex_d, ex_q;
  logic [31:0] npc_d, npc_q, rd1_d, rd1_q, rd2_d, rd2_q, sext_d, sext_q;
  logic [4:0]  rt_fld_d, rt_fld_q, rd_fld_d, rd_fld_q;

  logic [4:0]  rs, rt;
  logic        write_en;
  logic        bubble;

  assign rs       = IF_ID_instr[25:21];
  assign rt       = IF_ID_instr[20:16];
  assign write_en = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);

  always_comb begin
    ex_dec = 4'b0000;
    m_dec  = 3'b000;
    wb_dec = 2'b00;
    case (IF_ID_instr[31:26])
      c_op_rtype: begin ex_dec = 4'b1100; m_dec = 3'b000; wb_dec = 2'b10; end
      c_op_lw:    begin ex_dec = 4'b0001; m_dec = 3'b010; wb_dec = 2'b11; end
      c_op_sw:    begin ex_dec = 4'b0001; m_dec = 3'b001; wb_dec = 2'b00; end
      c_op_beq:   begin ex_dec = 4'b0010; m_dec = 3'b100; wb_dec = 2'b00; end
      default:    begin ex_dec = 4'b0000; m_dec = 3'b000; wb_dec = 2'b00; end
    endcase
  end

  // Writeback data bypasses storage so a same-cycle write is seen by decode.
  always_comb begin
    rd1_d = regs_q[rs];
    rd2_d = regs_q[rt];
    if (write_en && (rs == MEM_WB_WriteReg)) rd1_d = MEM_WB_WriteData;
    if (write_en && (rt == MEM_WB_WriteReg)) rd2_d = MEM_WB_WriteData;
    if (rs == 5'd0) rd1_d = 32'd0;
    if (rt == 5'd0) rd2_d = 32'd0;
  end

`ifdef ID_HAZARD_EN
  assign IF_ID_stall = m_q[1] && (rt_fld_q != 5'd0) &&
                       ((rt_fld_q == rs) || (rt_fld_q == rt));
`else
  assign IF_ID_stall = 1'b0;
`endif

  assign bubble = EX_MEM_PCSrc || IF_ID_stall;

  always_comb begin
    regs_d = regs_q;
    if (write_en) regs_d[MEM_WB_WriteReg] = MEM_WB_WriteData;
    wb_d     = bubble ? 2'b00   : wb_dec;
    m_d      = bubble ? 3'b000  : m_dec;
    ex_d     = bubble ? 4'b0000 : ex_dec;
    npc_d    = IF_ID_npc;
    sext_d   = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};
    rt_fld_d = IF_ID_instr[20:16];
    rd_fld_d = IF_ID_instr[15:11];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      wb_q     <= 2'b00;
      m_q      <= 3'b000;
      ex_q     <= 4'b0000;
      npc_q    <= 32'd0;
      rd1_q    <= 32'd0;
      rd2_q    <= 32'd0;
      sext_q   <= 32'd0;
      rt_fld_q <= 5'd0;
      rd_fld_q <= 5'd0;
    end else begin
      regs_q   <= regs_d;
      wb_q     <= wb_d;
      m_q      <= m_d;
      ex_q     <= ex_d;
      npc_q    <= npc_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      sext_q   <= sext_d;
      rt_fld_q <= rt_fld_d;
      rd_fld_q <= rd_fld_d;
    end
  end

  assign ID_EX_wb         = wb_q;
  assign ID_EX_m          = m_q;
  assign ID_EX_ex         = ex_q;
  assign ID_EX_npc        = npc_q;
  assign ID_EX_readdat1   = rd1_q;
  assign ID_EX_readdat2   = rd2_q;
  assign ID_EX_sign_ext   = sext_q;
  assign ID_EX_instr_2016 = rt_fld_q;
  assign ID_EX_instr_1511 = rd_fld_q;

endmodule
`default_nettype wire
